// File: rtl/dnn_pkg.sv
// Shared types and constants for the MNIST argmax classifier stage.
// Build option DNN_ARGMAX_MARGIN_EN (see dnn_argmax_classify) enables second-best tracking.
package dnn_pkg;

  localparam int unsigned N_CLASSES_DEF  = 10;
  localparam int unsigned DATA_WIDTH_DEF = 3;
  localparam int unsigned DIGIT_W        = 4;

  typedef logic signed [DATA_WIDTH_DEF-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } argmax_state_t;

endpackage

// File: rtl/dnn_top2_update.sv
// Combinational top-two update: folds one candidate score into (best, best_idx, second).
// Strict compares, so ties keep the earlier (lower) index.
module dnn_top2_update
  import dnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 3
) (
  input  logic signed [DATA_WIDTH-1:0] best_i,
  input  logic        [DIGIT_W-1:0]    best_idx_i,
  input  logic signed [DATA_WIDTH-1:0] second_i,
  input  logic signed [DATA_WIDTH-1:0] cand_i,
  input  logic        [DIGIT_W-1:0]    cand_idx_i,
  output logic signed [DATA_WIDTH-1:0] best_o,
  output logic        [DIGIT_W-1:0]    best_idx_o,
  output logic signed [DATA_WIDTH-1:0] second_o
);

  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
    second_o   = second_i;
    if (cand_i > best_i) begin
      second_o   = best_i;
      best_o     = cand_i;
      best_idx_o = cand_idx_i;
    end else if (cand_i > second_i) begin
      second_o = cand_i;
    end
  end

endmodule

// File: rtl/dnn_argmax_classify.sv
// Argmax classifier: captures N_CLASSES scores, scans one per cycle, holds the winner.
// Define DNN_ARGMAX_MARGIN_EN to build second-best tracking and drive margin/low_conf.
module dnn_argmax_classify
  import dnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned N_CLASSES  = N_CLASSES_DEF,
  parameter int unsigned MARGIN_THR = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [N_CLASSES-1:0][DATA_WIDTH-1:0] scores,
  output logic                                in_ready,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DIGIT_W-1:0]                  digit,
  output logic signed [DATA_WIDTH-1:0]        max_score,
  output logic [DATA_WIDTH:0]                 margin,
  output logic                                low_conf
);

  localparam logic signed [DATA_WIDTH-1:0] MinScore = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DIGIT_W-1:0]           LastIdx  = DIGIT_W'(N_CLASSES - 1);

  argmax_state_t                        state_q, state_d;
  logic                                 init_q;
  logic [N_CLASSES-1:0][DATA_WIDTH-1:0] score_q, score_d;
  logic signed [DATA_WIDTH-1:0]         best_q, best_d;
  logic [DIGIT_W-1:0]                   best_idx_q, best_idx_d;
  logic [DIGIT_W-1:0]                   idx_q, idx_d;
  logic [DIGIT_W-1:0]                   digit_q, digit_d;
  logic signed [DATA_WIDTH-1:0]         max_q, max_d;

  logic signed [DATA_WIDTH-1:0] cand;
  logic signed [DATA_WIDTH-1:0] upd_best;
  logic [DIGIT_W-1:0]           upd_idx;

  assign cand = score_q[idx_q];

`ifdef DNN_ARGMAX_MARGIN_EN
  logic signed [DATA_WIDTH-1:0] second_q, second_d;
  logic signed [DATA_WIDTH-1:0] upd_second;
  logic [DATA_WIDTH:0]          margin_q, margin_d;
  logic                         low_conf_q, low_conf_d;
  logic [DATA_WIDTH:0]          diff;

  // Sign-extend both operands one bit so the difference never wraps.
  assign diff = {upd_best[DATA_WIDTH-1], upd_best} - {upd_second[DATA_WIDTH-1], upd_second};

  dnn_top2_update #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_top2 (
    .best_i     (best_q),
    .best_idx_i (best_idx_q),
    .second_i   (second_q),
    .cand_i     (cand),
    .cand_idx_i (idx_q),
    .best_o     (upd_best),
    .best_idx_o (upd_idx),
    .second_o   (upd_second)
  );
`else
  logic signed [DATA_WIDTH-1:0] unused_second;

  dnn_top2_update #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_top2 (
    .best_i     (best_q),
    .best_idx_i (best_idx_q),
    .second_i   (MinScore),
    .cand_i     (cand),
    .cand_idx_i (idx_q),
    .best_o     (upd_best),
    .best_idx_o (upd_idx),
    .second_o   (unused_second)
  );
`endif

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    idx_d      = idx_q;
    digit_d    = digit_q;
    max_d      = max_q;
`ifdef DNN_ARGMAX_MARGIN_EN
    second_d   = second_q;
    margin_d   = margin_q;
    low_conf_d = low_conf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          score_d    = scores;
          best_d     = scores[0];
          best_idx_d = '0;
          idx_d      = DIGIT_W'(1);
`ifdef DNN_ARGMAX_MARGIN_EN
          second_d   = MinScore;
`endif
          state_d    = SCAN;
        end
      end
      SCAN: begin
        best_d     = upd_best;
        best_idx_d = upd_idx;
        idx_d      = idx_q + DIGIT_W'(1);
`ifdef DNN_ARGMAX_MARGIN_EN
        second_d   = upd_second;
`endif
        if (idx_q == LastIdx) begin
          digit_d = upd_idx;
          max_d   = upd_best;
`ifdef DNN_ARGMAX_MARGIN_EN
          margin_d   = diff;
          low_conf_d = 32'(diff) < MARGIN_THR;
`endif
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      init_q     <= 1'b0;
      score_q    <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      digit_q    <= '0;
      max_q      <= '0;
`ifdef DNN_ARGMAX_MARGIN_EN
      second_q   <= '0;
      margin_q   <= '0;
      low_conf_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      score_q    <= score_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      idx_q      <= idx_d;
      digit_q    <= digit_d;
      max_q      <= max_d;
`ifdef DNN_ARGMAX_MARGIN_EN
      second_q   <= second_d;
      margin_q   <= margin_d;
      low_conf_q <= low_conf_d;
`endif
    end
  end

  // init_q keeps in_ready low while reset is held, even though the state is IDLE.
  assign in_ready  = init_q && (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign digit     = digit_q;
  assign max_score = max_q;
`ifdef DNN_ARGMAX_MARGIN_EN
  assign margin    = margin_q;
  assign low_conf  = low_conf_q;
`else
  assign margin    = '0;
  assign low_conf  = 1'b0;
`endif

endmodule

// File: tb/tb_dnn_argmax_classify.sv
// Scoreboard bench for dnn_argmax_classify: driver pushes expected results, monitor pops on
// each out_valid rise. Margin expectations follow DNN_ARGMAX_MARGIN_EN.
module tb_dnn_argmax_classify;

`ifdef DNN_ARGMAX_MARGIN_EN
  localparam bit MarginEn = 1'b1;
`else
  localparam bit MarginEn = 1'b0;
`endif
  localparam int Lat = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [9:0][2:0] scores;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      digit;
  logic signed [2:0] max_score;
  logic [3:0]      margin;
  logic            low_conf;

  dnn_argmax_classify dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .scores    (scores),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digit     (digit),
    .max_score (max_score),
    .margin    (margin),
    .low_conf  (low_conf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int s [10];
    int dig;
    int mx;
    int mg;
    int lc;
  } vec_t;

  typedef struct {
    int dig;
    int mx;
    int mg;
    int lc;
    int cap;
  } exp_t;

  vec_t tbl [5];
  exp_t sb_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send(input int k, input bit track);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", int'(in_ready), 1);
    if (!in_ready) return;
    for (int i = 0; i < 10; i++) scores[i] = 3'(tbl[k].s[i]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (track) begin
      e.dig = tbl[k].dig;
      e.mx  = tbl[k].mx;
      e.mg  = MarginEn ? tbl[k].mg : 0;
      e.lc  = MarginEn ? tbl[k].lc : 0;
      e.cap = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic monitor();
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (in_ready && out_valid) check("ready_valid_overlap", 1, 0);
      if (out_valid && !prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("digit", int'(digit), e.dig);
          check("max_score", int'(max_score), e.mx);
          check("margin", int'(margin), e.mg);
          check("low_conf", int'(low_conf), e.lc);
          check("latency", cyc - e.cap, Lat);
        end
      end
      prev = out_valid;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string nm);
    check({nm, "_in_ready"}, int'(in_ready), 0);
    check({nm, "_out_valid"}, int'(out_valid), 0);
    check({nm, "_digit"}, int'(digit), 0);
    check({nm, "_max_score"}, int'(max_score), 0);
    check({nm, "_margin"}, int'(margin), 0);
    check({nm, "_low_conf"}, int'(low_conf), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{'{0, 1, 2, 3, -4, -1, 3, 0, 0, 0}, 3, 3, 0, 1};
    tbl[1] = '{'{-4, -4, -4, -4, -4, -4, -4, -4, -4, -4}, 0, -4, 0, 1};
    tbl[2] = '{'{-4, -4, -4, -4, -4, -4, -4, -4, -4, 3}, 9, 3, 7, 0};
    tbl[3] = '{'{0, 0, 1, 0, 0, 0, 0, 0, 0, 0}, 2, 1, 1, 0};
    tbl[4] = '{'{3, -4, -4, -4, -4, -4, -4, 2, -4, -4}, 0, 3, 1, 0};

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    scores    = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", int'(in_ready), 1);

    // Basic frames, back to back.
    send(0, 1'b1);
    send(1, 1'b1);
    send(2, 1'b1);
    drain();

    // Consumer backpressure with in_valid toggling during HOLD.
    out_ready = 1'b0;
    send(2, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 10; i++) scores[i] = 3'(tbl[3].s[i]);
      in_valid = c[0];
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_digit", int'(digit), 9);
      check("bp_max_score", int'(max_score), 3);
      check("bp_margin", int'(margin), MarginEn ? 7 : 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    send(4, 1'b1);
    drain();

    // Reset during the 4th SCAN cycle: no result may appear.
    send(2, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero_outputs("midscan_reset");
    repeat (3) @(negedge clk);
    check("midscan_reset_hold_out_valid", int'(out_valid), 0);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    send(3, 1'b1);
    drain();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
